// File: rtl/sram_mem_ctrl.sv
// Initiator for an asynchronous 16-bit SRAM: converts single-word req/ack transactions
// into timed CE/OE/WE/UB/LB strobes, a latched address and a tri-stated data bus.
module sram_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1  // extra strobe-active cycles, 0..15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        wr,
    input  logic [19:0] addr,
    input  logic [15:0] wdata,
    input  logic [1:0]  be,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [19:0] A,
    inout  wire  [15:0] I_O,
    output logic        CE,
    output logic        OE,
    output logic        WE,
    output logic        UB,
    output logic        LB
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;
    logic        io_drive;
    logic        accept;
    logic        rd_last;

    assign accept  = (state == IDLE) && req;
    assign rd_last = (state == RD_ACC) && (cnt == 4'd0);
    assign ack     = (state == DONE);
    assign busy    = (state != IDLE);

    // Strobes decode straight from the state register so an async reset releases the pins at once.
    assign I_O = io_drive ? wdata_q : 16'hzzzz;

    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        CE        = 1'b1;
        OE        = 1'b1;
        WE        = 1'b1;
        UB        = 1'b1;
        LB        = 1'b1;
        io_drive  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (be == 2'b00) begin
                        state_nxt = DONE;
                    end else if (wr) begin
                        state_nxt = WR_SETUP;
                    end else begin
                        state_nxt = RD_ACC;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            RD_ACC: begin
                CE = 1'b0;
                OE = 1'b0;
                UB = ~be_q[1];
                LB = ~be_q[0];
                if (cnt == 4'd0) state_nxt = DONE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            WR_SETUP: begin
                CE        = 1'b0;
                io_drive  = 1'b1;
                state_nxt = WR_PULSE;
                cnt_nxt   = WAIT_LOAD;
            end
            WR_PULSE: begin
                CE       = 1'b0;
                WE       = 1'b0;
                UB       = ~be_q[1];
                LB       = ~be_q[0];
                io_drive = 1'b1;
                if (cnt == 4'd0) state_nxt = WR_HOLD;
                else             cnt_nxt   = cnt - 4'd1;
            end
            WR_HOLD: begin
                CE        = 1'b0;
                io_drive  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values of the others.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            A       <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                A       <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
            if (rd_last) begin
                rdata <= {be_q[1] ? I_O[15:8] : 8'h00, be_q[0] ? I_O[7:0] : 8'h00};
            end
        end
    end

    // The SRAM drives I_O whenever OE is low, so driving it ourselves then would contend.
    a_no_contention: assert property (@(posedge Clk) disable iff (!Reset) !(io_drive && !OE));
    a_we_in_pulse:   assert property (@(posedge Clk) disable iff (!Reset) (!WE) |-> (state == WR_PULSE));

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: two instances (WAIT_CYCLES 1 and 3), each with its own SRAM model,
// compared every cycle against a schedule-based reference of the pin protocol.
module tb_sram_mem_ctrl;

    logic Clk;
    logic Reset;

    logic [1:0]        req;
    logic [1:0]        wr;
    logic [1:0][19:0]  addr;
    logic [1:0][15:0]  wdata;
    logic [1:0][1:0]   be;
    logic [1:0][15:0]  rdv;
    logic [1:0]        ackv;
    logic [1:0]        busyv;
    logic [1:0][19:0]  av;
    logic [1:0]        ce;
    logic [1:0]        oe;
    logic [1:0]        we;
    logic [1:0]        ub;
    logic [1:0]        lb;
    wire  [15:0]       io0;
    wire  [15:0]       io1;
    logic [1:0][15:0]  io_v;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    sram_mem_ctrl #(.WAIT_CYCLES(1)) dut0 (
        .Clk(Clk), .Reset(Reset), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
        .be(be[0]), .rdata(rdv[0]), .ack(ackv[0]), .busy(busyv[0]), .A(av[0]), .I_O(io0),
        .CE(ce[0]), .OE(oe[0]), .WE(we[0]), .UB(ub[0]), .LB(lb[0])
    );

    sram_mem_ctrl #(.WAIT_CYCLES(3)) dut1 (
        .Clk(Clk), .Reset(Reset), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
        .be(be[1]), .rdata(rdv[1]), .ack(ackv[1]), .busy(busyv[1]), .A(av[1]), .I_O(io1),
        .CE(ce[1]), .OE(oe[1]), .WE(we[1]), .UB(ub[1]), .LB(lb[1])
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int wc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int op_len(input logic w, input logic [1:0] b, input int wcy);
        if (b == 2'b00) return 1;
        return w ? wcy + 4 : wcy + 2;
    endfunction

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h5AC3;
    endfunction

    function automatic logic [15:0] lane_mask(input logic [15:0] v, input logic [1:0] b);
        return {b[1] ? v[15:8] : 8'h00, b[0] ? v[7:0] : 8'h00};
    endfunction

    function automatic logic [15:0] lane_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                               input logic [1:0] b);
        return {b[1] ? new_v[15:8] : old_v[15:8], b[0] ? new_v[7:0] : old_v[7:0]};
    endfunction

    // SRAM device models: read drives the whole word, writes latch on the WE rising transition.
    logic [15:0] sram_mem [2][256];
    logic        sram_init;
    logic [1:0]       pend_v;
    logic [1:0][7:0]  pend_a;
    logic [1:0][15:0] pend_d;
    logic [1:0][1:0]  pend_be;

    assign io0 = (!ce[0] && !oe[0] && we[0]) ? sram_mem[0][av[0][7:0]] : 16'hzzzz;
    assign io1 = (!ce[1] && !oe[1] && we[1]) ? sram_mem[1][av[1][7:0]] : 16'hzzzz;
    assign io_v[0] = io0;
    assign io_v[1] = io1;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            if (sram_init !== 1'b1) begin
                for (int i = 0; i < 256; i++) begin
                    sram_mem[0][i] <= init_word(i);
                    sram_mem[1][i] <= init_word(i);
                end
                sram_init <= 1'b1;
            end
            pend_v <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!ce[d] && !we[d]) begin
                    pend_v[d]  <= 1'b1;
                    pend_a[d]  <= av[d][7:0];
                    pend_d[d]  <= io_v[d];
                    pend_be[d] <= {~ub[d], ~lb[d]};
                end else if (pend_v[d]) begin
                    sram_mem[d][pend_a[d]] <= lane_merge(sram_mem[d][pend_a[d]], pend_d[d], pend_be[d]);
                    pend_v[d] <= 1'b0;
                end
            end
        end
    end

    // Reference: a transaction is an accept time plus a fixed per-cycle pin schedule.
    logic [15:0]      ref_mem [2][256];
    logic             ref_init;
    logic [1:0]       m_act;
    logic [1:0]       m_wr;
    int               m_t [2];
    logic [1:0][1:0]  m_be;
    logic [1:0][19:0] m_a;
    logic [1:0][15:0] m_wdata;
    logic [1:0][15:0] m_rdata;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            if (ref_init !== 1'b1) begin
                for (int i = 0; i < 256; i++) begin
                    ref_mem[0][i] <= init_word(i);
                    ref_mem[1][i] <= init_word(i);
                end
                ref_init <= 1'b1;
            end
            m_act   <= '0;
            m_wr    <= '0;
            m_be    <= '0;
            m_a     <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
            for (int d = 0; d < 2; d++) m_t[d] <= 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_act[d]) begin
                    if (req[d]) begin
                        m_act[d]   <= 1'b1;
                        m_t[d]     <= 1;
                        m_wr[d]    <= wr[d];
                        m_be[d]    <= be[d];
                        m_a[d]     <= addr[d];
                        m_wdata[d] <= wdata[d];
                    end
                end else begin
                    if (m_t[d] >= op_len(m_wr[d], m_be[d], wc(d))) m_act[d] <= 1'b0;
                    else                                           m_t[d]   <= m_t[d] + 1;
                    if (m_be[d] != 2'b00 && !m_wr[d] && m_t[d] == wc(d) + 1)
                        m_rdata[d] <= lane_mask(ref_mem[d][m_a[d][7:0]], m_be[d]);
                    if (m_be[d] != 2'b00 && m_wr[d] && m_t[d] == wc(d) + 3)
                        ref_mem[d][m_a[d][7:0]] <= lane_merge(ref_mem[d][m_a[d][7:0]], m_wdata[d], m_be[d]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_dut(input int d);
        int         w;
        int         t;
        int         len;
        logic       act;
        logic       rd_ph;
        logic       wp_ph;
        logic       drv;
        logic [6:0] exp_s;
        logic [6:0] act_s;
        w     = wc(d);
        t     = m_t[d];
        act   = m_act[d];
        len   = op_len(m_wr[d], m_be[d], w);
        rd_ph = act && !m_wr[d] && (m_be[d] != 2'b00) && (t <= w + 1);
        wp_ph = act && m_wr[d] && (m_be[d] != 2'b00) && (t >= 2) && (t <= w + 2);
        drv   = act && m_wr[d] && (m_be[d] != 2'b00) && (t <= w + 3);
        exp_s = {~(act && t < len), ~rd_ph, ~wp_ph,
                 ~((rd_ph || wp_ph) && m_be[d][1]), ~((rd_ph || wp_ph) && m_be[d][0]),
                 act && (t == len), act};
        act_s = {ce[d], oe[d], we[d], ub[d], lb[d], ackv[d], busyv[d]};
        check($sformatf("pins{ce,oe,we,ub,lb,ack,busy}[dut%0d]", d), 32'(act_s), 32'(exp_s));
        check($sformatf("A[dut%0d]", d), 32'(av[d]), 32'(m_a[d]));
        check($sformatf("rdata[dut%0d]", d), 32'(rdv[d]), 32'(m_rdata[d]));
        if (drv) check($sformatf("io_drive[dut%0d]", d), 32'(io_v[d]), 32'(m_wdata[d]));
    endtask

    always @(negedge Clk) begin
        for (int d = 0; d < 2; d++) compare_dut(d);
    end

    // One request from IDLE; inputs are scrambled right after acceptance.
    task automatic access(input int d, input logic w, input logic [19:0] ad, input logic [15:0] wd,
                          input logic [1:0] b, output int lat, output int we_lo);
        int k;
        int n;
        @(negedge Clk);
        n = 0;
        while (busyv[d] && n < 64) begin
            @(negedge Clk);
            n++;
        end
        req[d] = 1'b1; wr[d] = w; addr[d] = ad; wdata[d] = wd; be[d] = b;
        k = cyc;
        @(negedge Clk);
        req[d] = 1'b0; wr[d] = 1'($urandom); addr[d] = 20'($urandom);
        wdata[d] = 16'($urandom); be[d] = 2'($urandom);
        we_lo = 0;
        n = 0;
        while (!ackv[d] && n < 64) begin
            if (!we[d]) we_lo++;
            @(negedge Clk);
            n++;
        end
        check($sformatf("ack_seen[dut%0d]", d), 32'(ackv[d]), 32'd1);
        lat = cyc - k;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          wl;
        int          acks;
        int          n;
        logic [15:0] last_w;
        req = '0; wr = '0; addr = '0; wdata = '0; be = '0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        check("reset_ce", 32'(ce[0]), 32'd1);
        check("reset_we", 32'(we[0]), 32'd1);
        check("reset_busy", 32'(busyv[0]), 32'd0);
        check("reset_a", 32'(av[0]), 32'd0);
        check("reset_rdata", 32'(rdv[0]), 32'd0);
        #19 Reset = 1'b1;

        access(0, 1'b1, 20'h00003, 16'hBEEF, 2'b11, lat, wl);
        check("wr_latency", 32'(lat), 32'd5);
        check("wr_we_low_cycles", 32'(wl), 32'd2);
        access(0, 1'b0, 20'h00003, 16'h0000, 2'b11, lat, wl);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_beef", 32'(rdv[0]), 32'h0000BEEF);

        access(0, 1'b1, 20'h00003, 16'h1234, 2'b01, lat, wl);
        check("wr_lower_latency", 32'(lat), 32'd5);
        access(0, 1'b0, 20'h00003, 16'h0000, 2'b11, lat, wl);
        check("rd_merged", 32'(rdv[0]), 32'h0000BE34);
        access(0, 1'b0, 20'h00003, 16'h0000, 2'b10, lat, wl);
        check("rd_upper_only", 32'(rdv[0]), 32'h0000BE00);

        access(0, 1'b0, 20'h00003, 16'h0000, 2'b00, lat, wl);
        check("be00_latency", 32'(lat), 32'd1);
        check("be00_rdata_kept", 32'(rdv[0]), 32'h0000BE00);

        access(0, 1'b1, 20'h00005, 16'h1357, 2'b11, lat, wl);
        @(negedge Clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 20'h00005; wdata[0] = 16'hAAAA; be[0] = 2'b11;
        @(negedge Clk);
        req[0] = 1'b0;
        @(negedge Clk);
        check("pulse_we_low", 32'(we[0]), 32'd0);
        @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("midpulse_reset_we", 32'(we[0]), 32'd1);
        check("midpulse_reset_ce", 32'(ce[0]), 32'd1);
        check("midpulse_reset_busy", 32'(busyv[0]), 32'd0);
        check("midpulse_reset_a", 32'(av[0]), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        #2 Reset = 1'b1;
        access(0, 1'b0, 20'h00005, 16'h0000, 2'b11, lat, wl);
        check("aborted_write_kept", 32'(rdv[0]), 32'h00001357);

        @(negedge Clk);
        last_w = 16'hC0DE;
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 20'h00010; wdata[0] = last_w; be[0] = 2'b11;
        acks = 0;
        n = 0;
        while (acks < 6 && n < 200) begin
            @(negedge Clk);
            n++;
            if (ackv[0]) begin
                acks++;
                if (!wr[0]) check("held_req_rdata", 32'(rdv[0]), 32'(last_w));
                wr[0] = ~wr[0];
                if (wr[0]) begin
                    last_w = 16'($urandom);
                    wdata[0] = last_w;
                end
            end
        end
        req[0] = 1'b0;
        check("held_req_acks", 32'(acks), 32'd6);

        access(1, 1'b1, 20'h00003, 16'hBEEF, 2'b11, lat, wl);
        check("w3_wr_latency", 32'(lat), 32'd7);
        check("w3_we_low_cycles", 32'(wl), 32'd4);
        access(1, 1'b0, 20'h00003, 16'h0000, 2'b11, lat, wl);
        check("w3_rd_latency", 32'(lat), 32'd5);
        check("w3_rd_beef", 32'(rdv[1]), 32'h0000BEEF);

        for (int c = 0; c < 2500; c++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                req[d]   = ($urandom_range(0, 2) != 0);
                wr[d]    = 1'($urandom);
                addr[d]  = 20'($urandom_range(0, 15));
                wdata[d] = 16'($urandom);
                be[d]    = 2'($urandom);
            end
            if (c == 1200) begin
                #2 Reset = 1'b0;
                #6 Reset = 1'b1;
            end
        end
        @(negedge Clk);
        req = '0;
        repeat (12) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
